avalon_wait_bridge: RTL and testbench

Avalon-MM pipeline bridge inserted between the `mips_cpu_bus` master port and the `mips_avalon_slave` memory in the CPU test harness. It accepts one CPU transaction at a time and holds `waitrequest` high for an extra N cycles before forwarding the transaction to memory. N is either fixed or drawn from an LFSR. This stresses the CPU's stall handling. The bridge also counts completed transactions and flags master-side protocol violations.

---
 rtl/avalon_wait_bridge.sv | 114 +++++++++++
 tb/tb_avalon_wait_bridge.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_wait_bridge.sv
// Avalon-MM bridge that holds each CPU transaction for N extra wait cycles before
// forwarding it to memory; counts completed transactions and flags master misuse.
module avalon_wait_bridge #(
  parameter int unsigned MAX_WAIT  = 3,
  parameter bit          RANDOM    = 1'b1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_address,
  input  logic [3:0]  s_byteenable,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic        s_waitrequest,
  output logic [31:0] s_readdata,
  output logic [31:0] m_address,
  output logic [3:0]  m_byteenable,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic [31:0] txn_count,
  output logic        protocol_error
);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, DONE} state_t;

  // An all-zero Galois LFSR never leaves zero.
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [8:0]  WAIT_MOD  = 9'(MAX_WAIT + 1);
  localparam logic [7:0]  WAIT_FIX  = 8'(MAX_WAIT);

  state_t      state, state_nxt;
  logic [7:0]  wcnt;
  logic [15:0] lfsr;
  logic [31:0] req_address;
  logic [3:0]  req_byteenable;
  logic [31:0] req_writedata;
  logic        req_read;
  logic        req_write;

  logic        accept;
  logic        busy;
  logic        req_changed;
  logic [7:0]  n_wait;

  assign accept = (state == IDLE) && (s_read || s_write);
  assign busy   = (state == WAIT) || (state == ISSUE);
  assign n_wait = RANDOM ? 8'({1'b0, lfsr[7:0]} % WAIT_MOD) : WAIT_FIX;

  assign req_changed = (s_address != req_address) || (s_byteenable != req_byteenable) ||
                       (s_read != req_read) || (s_write != req_write) ||
                       (req_write && (s_writedata != req_writedata));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (n_wait != 8'd0) ? WAIT : ISSUE;
      WAIT:    if (wcnt == 8'd1) state_nxt = ISSUE;
      ISSUE:   if (!m_waitrequest) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the capture registers feed the memory-side outputs directly, so they are reset too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt           <= 8'd0;
      lfsr           <= SEED;
      req_address    <= 32'd0;
      req_byteenable <= 4'd0;
      req_writedata  <= 32'd0;
      req_read       <= 1'b0;
      req_write      <= 1'b0;
      s_readdata     <= 32'd0;
      txn_count      <= 32'd0;
      protocol_error <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      if (accept) begin
        req_address    <= s_address;
        req_byteenable <= s_byteenable;
        req_writedata  <= s_writedata;
        req_read       <= s_read;
        req_write      <= s_write && !s_read;  // read wins a read+write collision
        wcnt           <= n_wait;
        lfsr           <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
        if (s_read && s_write) protocol_error <= 1'b1;
      end
      if (state == WAIT) wcnt <= wcnt - 8'd1;
      if (busy && req_changed) protocol_error <= 1'b1;
      if ((state == ISSUE) && !m_waitrequest && req_read) s_readdata <= m_readdata;
      if (state == DONE) txn_count <= txn_count + 32'd1;
    end
  end

  assign s_waitrequest = (state != DONE);
  assign m_read        = (state == ISSUE) && req_read;
  assign m_write       = (state == ISSUE) && req_write;
  assign m_address     = req_address;
  assign m_byteenable  = req_byteenable;
  assign m_writedata   = req_writedata;

endmodule

// File: tb/tb_avalon_wait_bridge.sv
// Bench for avalon_wait_bridge: a fixed-wait and a random-wait instance checked every
// cycle against a timeline model, plus directed scenarios with literal expectations.
module tb_avalon_wait_bridge;

  localparam int F_MAX = 3;
  localparam int R_MAX = 3;
  localparam logic [15:0] R_SEED = 16'hACE1;
  localparam int NEVER = 32'h7fff_ffff;

  typedef struct {
    int          t0;
    int          n;
    int          m;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  // fixed-wait instance signals
  logic [31:0] f_s_address = '0, f_s_writedata = '0, f_s_readdata;
  logic [3:0]  f_s_byteenable = '0, f_m_byteenable;
  logic        f_s_read = 1'b0, f_s_write = 1'b0, f_s_waitrequest;
  logic [31:0] f_m_address, f_m_writedata, f_m_readdata, f_txn_count;
  logic        f_m_read, f_m_write, f_m_waitrequest, f_protocol_error;

  // random-wait instance signals
  logic [31:0] r_s_address = '0, r_s_writedata = '0, r_s_readdata;
  logic [3:0]  r_s_byteenable = '0, r_m_byteenable;
  logic        r_s_read = 1'b0, r_s_write = 1'b0, r_s_waitrequest;
  logic [31:0] r_m_address, r_m_writedata, r_m_readdata, r_txn_count;
  logic        r_m_read, r_m_write, r_m_waitrequest, r_protocol_error;

  // model state written by the stimulus process
  txn_t        cur [2];
  int          issue_cnt [2] = '{0, 0};
  int          perr_from [2] = '{NEVER, NEVER};
  int          stall_cfg [2] = '{0, 0};
  logic [15:0] lfsr_m = R_SEED;
  // model state written by the compare process
  int          done_cnt [2] = '{0, 0};
  logic [31:0] exp_count [2] = '{32'd0, 32'd0};
  logic [31:0] exp_rdata [2] = '{32'd0, 32'd0};
  // memory stall counters
  int          f_busy = 0, r_busy = 0;

  int pin_n [5] = '{1, 0, 0, 0, 2};
  int hist [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_wait_bridge #(.MAX_WAIT(F_MAX), .RANDOM(1'b0), .LFSR_SEED(R_SEED)) dut_fix (
    .clk(clk), .reset(reset),
    .s_address(f_s_address), .s_byteenable(f_s_byteenable), .s_read(f_s_read),
    .s_write(f_s_write), .s_writedata(f_s_writedata), .s_waitrequest(f_s_waitrequest),
    .s_readdata(f_s_readdata), .m_address(f_m_address), .m_byteenable(f_m_byteenable),
    .m_read(f_m_read), .m_write(f_m_write), .m_writedata(f_m_writedata),
    .m_waitrequest(f_m_waitrequest), .m_readdata(f_m_readdata),
    .txn_count(f_txn_count), .protocol_error(f_protocol_error));

  avalon_wait_bridge #(.MAX_WAIT(R_MAX), .RANDOM(1'b1), .LFSR_SEED(R_SEED)) dut_rnd (
    .clk(clk), .reset(reset),
    .s_address(r_s_address), .s_byteenable(r_s_byteenable), .s_read(r_s_read),
    .s_write(r_s_write), .s_writedata(r_s_writedata), .s_waitrequest(r_s_waitrequest),
    .s_readdata(r_s_readdata), .m_address(r_m_address), .m_byteenable(r_m_byteenable),
    .m_read(r_m_read), .m_write(r_m_write), .m_writedata(r_m_writedata),
    .m_waitrequest(r_m_waitrequest), .m_readdata(r_m_readdata),
    .txn_count(r_txn_count), .protocol_error(r_protocol_error));

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h8C02_0004;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  // memory models: hold waitrequest for stall_cfg cycles of each access
  assign f_m_readdata    = mem_data(f_m_address);
  assign r_m_readdata    = mem_data(r_m_address);
  assign f_m_waitrequest = (f_m_read || f_m_write) && (f_busy < stall_cfg[0]);
  assign r_m_waitrequest = (r_m_read || r_m_write) && (r_busy < stall_cfg[1]);
  always @(posedge clk) begin
    f_busy <= (f_m_read || f_m_write) ? f_busy + 1 : 0;
    r_busy <= (r_m_read || r_m_write) ? r_busy + 1 : 0;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Per-cycle comparison of one instance against the transaction timeline.
  task automatic cmp(input int d, input logic wreq, input logic mrd, input logic mwr,
                     input logic [31:0] maddr, input logic [3:0] mbe, input logic [31:0] mwd,
                     input logic [31:0] rdata, input logic [31:0] cnt, input logic perr);
    string p;
    bit act, at_done, e_rd, e_wr;
    int k, lo, hi;
    p = $sformatf("dut%0d c%0d", d, cyc);
    if (!reset) begin
      done_cnt[d]  = issue_cnt[d];
      exp_count[d] = 32'd0;
      exp_rdata[d] = 32'd0;
      check({p, " rst waitrequest"}, wreq, 1);
      check({p, " rst m_rd_wr"}, {mrd, mwr}, 0);
      check({p, " rst m_address"}, maddr, 0);
      check({p, " rst readdata"}, rdata, 0);
      check({p, " rst txn_count"}, cnt, 0);
      check({p, " rst protocol_error"}, perr, 0);
      return;
    end
    act     = (issue_cnt[d] != done_cnt[d]);
    k       = cyc - cur[d].t0;
    lo      = cur[d].n + 1;
    hi      = cur[d].n + 1 + cur[d].m;
    at_done = act && (k == hi + 1);
    e_rd    = act && cur[d].rd && (k >= lo) && (k <= hi);
    e_wr    = act && cur[d].wr && (k >= lo) && (k <= hi);
    check({p, " waitrequest"}, wreq, !at_done);
    check({p, " m_read"}, mrd, e_rd);
    check({p, " m_write"}, mwr, e_wr);
    check({p, " protocol_error"}, perr, cyc >= perr_from[d]);
    check({p, " txn_count"}, cnt, exp_count[d]);
    if (e_rd || e_wr) begin
      check({p, " m_address"}, maddr, cur[d].addr);
      check({p, " m_byteenable"}, mbe, cur[d].be);
      if (e_wr) check({p, " m_writedata"}, mwd, cur[d].wd);
    end
    if (at_done) begin
      if (cur[d].rd) exp_rdata[d] = mem_data(cur[d].addr);
      exp_count[d] = exp_count[d] + 32'd1;
      done_cnt[d]++;
    end
    check({p, " s_readdata"}, rdata, exp_rdata[d]);
  endtask

  always @(negedge clk) begin
    cmp(0, f_s_waitrequest, f_m_read, f_m_write, f_m_address, f_m_byteenable,
        f_m_writedata, f_s_readdata, f_txn_count, f_protocol_error);
    cmp(1, r_s_waitrequest, r_m_read, r_m_write, r_m_address, r_m_byteenable,
        r_m_writedata, r_s_readdata, r_txn_count, r_protocol_error);
  end

  task automatic drive(input int d, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    if (d == 0) begin
      f_s_read = rd; f_s_write = wr; f_s_address = a; f_s_byteenable = be; f_s_writedata = wd;
    end else begin
      r_s_read = rd; r_s_write = wr; r_s_address = a; r_s_byteenable = be; r_s_writedata = wd;
    end
  endtask

  task automatic idle(input int d);
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask

  // Presents one request in the next cycle and holds it until DONE is seen.
  task automatic run_txn(input int d, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd, input int stall,
                         input int chg_k, input logic [31:0] chg_a,
                         output int first_k, output int rd_cyc, output int wr_cyc,
                         output int done_k);
    int t0, k;
    @(posedge clk); #1;
    t0 = cyc;
    cur[d].t0 = t0;
    if (d == 0) cur[d].n = F_MAX;
    else begin
      cur[d].n = int'(lfsr_m[7:0]) % (R_MAX + 1);
      lfsr_m = lfsr_step(lfsr_m);
    end
    cur[d].m = stall;   cur[d].rd = rd;   cur[d].wr = wr && !rd;
    cur[d].addr = a;    cur[d].be = be;   cur[d].wd = wd;
    if (rd && wr && perr_from[d] > t0 + 1) perr_from[d] = t0 + 1;
    stall_cfg[d] = stall;
    issue_cnt[d]++;
    drive(d, rd, wr, a, be, wd);
    first_k = -1; rd_cyc = 0; wr_cyc = 0; done_k = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      k = cyc - t0;
      if (d == 0 ? f_m_read : r_m_read) begin rd_cyc++; if (first_k < 0) first_k = k; end
      if (d == 0 ? f_m_write : r_m_write) begin wr_cyc++; if (first_k < 0) first_k = k; end
      if (!(d == 0 ? f_s_waitrequest : r_s_waitrequest)) begin done_k = k; break; end
      @(posedge clk); #1;
      if (cyc - t0 == chg_k) begin
        if (d == 0) f_s_address = chg_a; else r_s_address = chg_a;
        if (perr_from[d] > cyc + 1) perr_from[d] = cyc + 1;
      end
    end
    if (done_k < 0) check("txn timeout (done seen)", 0, 1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fk, rc, wc, dk, n_meas;

    // reset values
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset waitrequest", f_s_waitrequest, 1);
    check("reset m_read", f_m_read, 0);
    check("reset m_write", f_m_write, 0);
    check("reset txn_count", f_txn_count, 0);
    check("reset protocol_error", f_protocol_error, 0);
    check("reset m_writedata", f_m_writedata, 0);

    // fixed-wait read against zero-wait memory
    run_txn(0, 1'b1, 1'b0, 32'hBFC0_0000, 4'hF, 32'd0, 0, -1, 32'd0, fk, rc, wc, dk);
    check("read first m_read cycle", fk, 4);
    check("read m_read cycles", rc, 1);
    check("read done cycle", dk, 5);
    check("read s_readdata", f_s_readdata, 32'h8C02_0004);
    idle(0);
    @(negedge clk);
    check("read txn_count", f_txn_count, 1);

    // write while memory stalls two cycles
    run_txn(0, 1'b0, 1'b1, 32'h0000_1000, 4'b0011, 32'h0000_ABCD, 2, -1, 32'd0,
            fk, rc, wc, dk);
    check("write first m_write cycle", fk, 4);
    check("write m_write cycles", wc, 3);
    check("write done cycle", dk, 7);
    check("write keeps s_readdata", f_s_readdata, 32'h8C02_0004);
    idle(0);
    @(negedge clk);
    check("write txn_count", f_txn_count, 2);
    check("no error before collision", f_protocol_error, 0);

    // read and write together: read only, error raised
    run_txn(0, 1'b1, 1'b1, 32'h0000_0200, 4'hF, 32'hDEAD_BEEF, 0, -1, 32'd0,
            fk, rc, wc, dk);
    check("collision m_read cycles", rc, 1);
    check("collision m_write cycles", wc, 0);
    check("collision protocol_error", f_protocol_error, 1);
    idle(0);

    // reset during ISSUE drops m_read immediately
    @(posedge clk); #1;
    cur[0].t0 = cyc; cur[0].n = F_MAX; cur[0].m = 10; cur[0].rd = 1'b1; cur[0].wr = 1'b0;
    cur[0].addr = 32'h0000_0300; cur[0].be = 4'hF; cur[0].wd = 32'd0;
    stall_cfg[0] = 10;
    issue_cnt[0]++;
    drive(0, 1'b1, 1'b0, 32'h0000_0300, 4'hF, 32'd0);
    for (int i = 0; i < 20 && !f_m_read; i++) @(negedge clk);
    check("m_read before async reset", f_m_read, 1);
    #2 reset = 1'b0;
    #1;
    check("async reset m_read", f_m_read, 0);
    check("async reset waitrequest", f_s_waitrequest, 1);
    check("async reset protocol_error", f_protocol_error, 0);
    drive(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    perr_from[0] = NEVER; perr_from[1] = NEVER;
    lfsr_m = R_SEED;
    stall_cfg[0] = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // address change while waiting
    run_txn(0, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'd0, 0, 1, 32'h0000_0104,
            fk, rc, wc, dk);
    check("addr change done cycle", dk, 5);
    check("addr change protocol_error", f_protocol_error, 1);
    idle(0);
    repeat (3) @(negedge clk);
    check("protocol_error sticky", f_protocol_error, 1);

    // 1000 back-to-back random-wait reads
    for (int i = 0; i < 1000; i++) begin
      run_txn(1, 1'b1, 1'b0, 32'h2000_0000 + 32'(i * 4), 4'hF, 32'd0, i % 3, -1, 32'd0,
              fk, rc, wc, dk);
      n_meas = fk - 1;
      check($sformatf("rnd %0d N in range", i), (n_meas >= 0 && n_meas <= R_MAX), 1);
      if (n_meas >= 0 && n_meas <= R_MAX) hist[n_meas]++;
      if (i < 5) check($sformatf("rnd %0d N literal", i), n_meas, pin_n[i]);
    end
    idle(1);
    @(negedge clk);
    check("rnd txn_count", r_txn_count, 1000);
    check("rnd protocol_error", r_protocol_error, 0);
    for (int v = 0; v <= R_MAX; v++) check($sformatf("rnd N=%0d occurs", v), hist[v] > 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
